// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the instruction fetch slice.
//   fetch_state_e : fetch FSM state encoding (IDLE, FETCH, FULL)
//   FIFO_DEPTH    : number of entries in the fetch buffer
//   FIFO_CNT_W    : width of an occupancy count able to hold 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_e;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Two-entry {instr, pc} buffer. The head entry lives in its own register, so
// head_instr/head_pc are direct flop outputs.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   flush                  : drop all entries (overrides push/pop)
//   push, push_instr/pc    : write one entry
//   pop                    : remove the head entry
//   head_instr, head_pc    : current head entry
//   full, empty            : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_instr,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    output logic [DATA_W-1:0] head_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic              full,
    output logic              empty
);

    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0]     head_instr_q, head_instr_d;
    logic [ADDR_W-1:0]     head_pc_q, head_pc_d;
    logic [DATA_W-1:0]     tail_instr_q, tail_instr_d;
    logic [ADDR_W-1:0]     tail_pc_q, tail_pc_d;
    logic                  eff_pop;
    logic                  eff_push;

    assign full  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // A pop on empty is ignored; a push when full is only taken alongside a pop.
    assign eff_pop  = pop && !empty;
    assign eff_push = push && (!full || eff_pop);

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;

        if (flush) begin
            count_d = '0;
        end else if (eff_push && eff_pop) begin
            if (count_q == FIFO_CNT_W'(1)) begin
                head_instr_d = push_instr;
                head_pc_d    = push_pc;
            end else begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
                tail_instr_d = push_instr;
                tail_pc_d    = push_pc;
            end
        end else if (eff_pop) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            count_d      = count_q - FIFO_CNT_W'(1);
        end else if (eff_push) begin
            if (empty) begin
                head_instr_d = push_instr;
                head_pc_d    = push_pc;
            end else begin
                tail_instr_d = push_instr;
                tail_pc_d    = push_pc;
            end
            count_d = count_q + FIFO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign head_instr = head_instr_q;
    assign head_pc    = head_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetcher in front of a 1-cycle-latency instruction
// RAM, feeding decode through a 2-entry buffer (fetch_fifo).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mem_addr, mem_we, mem_rd : RAM request (mem_we tied low)
//   mem_dout                 : RAM read data, one cycle after the request edge
//   instr, instr_pc          : buffer head, with instr_valid
//   instr_ready              : decode accepts the head this cycle
//   redir_valid, redir_pc    : flush and restart fetching at redir_pc
//   stall_cnt                : cycles with instr_valid && !instr_ready,
//                              saturating; present only when the macro
//                              FETCH_PERF_CNT_EN is defined
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
)
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [1:0]        occ;
    logic [1:0]        credit;
    logic [1:0]        next_total;

    assign mem_we      = 1'b0;
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign push        = inflight_q && !redir_valid;

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redir_valid),
        .push       (push),
        .push_instr (mem_dout),
        .push_pc    (inflight_pc_q),
        .pop        (pop),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        occ        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
        // The head leaving this cycle frees a slot, so a request can still
        // issue at buffer+in-flight = 2; this keeps one transfer per cycle.
        credit     = occ + 2'(inflight_q) - 2'(pop);

        mem_rd     = 1'b0;
        mem_addr   = pc_q;
        state_d    = state_q;

        if (rst) begin
            mem_addr = RESET_ADDR;
        end else if (redir_valid) begin
            mem_rd   = 1'b1;
            mem_addr = redir_pc;
        end else if (state_q != IDLE) begin
            mem_rd   = (credit < 2'd2);
        end

        next_total = (redir_valid ? 2'd0 : credit) + 2'(mem_rd);

        pc_d          = mem_rd ? (mem_addr + ADDR_W'(1)) : pc_q;
        inflight_d    = mem_rd;
        inflight_pc_d = mem_addr;

        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (!redir_valid && next_total == 2'd2) state_d = FULL;
            FULL:    if (redir_valid || pop) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (instr_valid && !instr_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. The reference model tracks the
// delivered instruction stream (next expected pc, next expected request
// address, words requested but not yet delivered) and the spec's timing
// rules. Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RESET_PC = 0;
    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_PC);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_dout = '0;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic              redir_valid = 1'b0;
    logic [ADDR_W-1:0] redir_pc = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_dout    (mem_dout),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Instruction RAM: word i holds 0x1000 + i, data one cycle after request.
    logic [DATA_W-1:0] ram [2**ADDR_W];
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 32'h1000 + 32'(i);
    end
    always @(posedge clk) begin
        if (mem_rd) mem_dout <= ram[mem_addr];
    end

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        return 32'h1000 + 32'(a);
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state
    logic [ADDR_W-1:0] m_exp_pc   = RST_ADDR;
    logic [ADDR_W-1:0] m_req_pc   = RST_ADDR;
    int                m_out      = 0;
    int                m_stall    = 0;
    bit                m_prev_rst = 1'b0;
    bit                m_prev_rdr = 1'b0;
    bit                m_hold     = 1'b0;
    logic [DATA_W-1:0] m_hold_instr;
    logic [ADDR_W-1:0] m_hold_pc;
    logic [ADDR_W-1:0] m_last_xfer_pc = '0;
    bit                saw_wrap = 1'b0;
    int                n_xfer   = 0;

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [ADDR_W-1:0] rp);
        bit xfer;
        @(negedge clk);
        rst         = r;
        instr_ready = rdy;
        redir_valid = rv;
        redir_pc    = rp;
        #1;
        check("mem_we", mem_we, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 64'(m_stall));
`endif
        if (r) begin
            check("rst_mem_rd", mem_rd, 1'b0);
            check("rst_mem_addr", mem_addr, RST_ADDR);
            if (m_prev_rst) begin
                check("rst_valid", instr_valid, 1'b0);
                check("rst_instr", instr, '0);
                check("rst_instr_pc", instr_pc, '0);
            end
            m_exp_pc   = RST_ADDR;
            m_req_pc   = RST_ADDR;
            m_out      = 0;
            m_stall    = 0;
            m_prev_rst = 1'b1;
            m_prev_rdr = 1'b0;
            m_hold     = 1'b0;
            return;
        end

        if (m_prev_rst || m_prev_rdr) check("flushed_valid", instr_valid, 1'b0);
        if (m_hold) begin
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instr, m_hold_instr);
            check("hold_pc", instr_pc, m_hold_pc);
        end

        xfer = instr_valid && rdy;
        if (xfer) begin
            check("xfer_pc", instr_pc, m_exp_pc);
            check("xfer_instr", instr, word_at(m_exp_pc));
            if (m_exp_pc == '0 && m_last_xfer_pc == '1) saw_wrap = 1'b1;
            m_last_xfer_pc = m_exp_pc;
            m_exp_pc       = m_exp_pc + 1'b1;
            m_out          = m_out - 1;
            n_xfer++;
        end
        if (instr_valid && !rdy) m_stall++;

        if (rv) begin
            check("redir_rd", mem_rd, 1'b1);
            check("redir_addr", mem_addr, rp);
            m_exp_pc = rp;
            m_req_pc = rp + 1'b1;
            m_out    = 1;
        end else if (m_prev_rst) begin
            check("idle_rd", mem_rd, 1'b0);
        end else begin
            // Fetch eagerly whenever buffered + outstanding words stay below two.
            check("rd_rule", mem_rd, (m_out < 2));
            if (mem_rd) begin
                check("req_addr", mem_addr, m_req_pc);
                m_req_pc = m_req_pc + 1'b1;
                m_out++;
            end
        end

        m_hold       = instr_valid && !rdy && !rv;
        m_hold_instr = instr;
        m_hold_pc    = instr_pc;
        m_prev_rst   = 1'b0;
        m_prev_rdr   = rv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;

        // Reset, then stream with decode always ready.
        repeat (2) step(1, 1, 0, '0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, '0);
            if (i == 0) check("a_idle_rd", mem_rd, 1'b0);
            if (i == 1) check("a_first_rd", mem_rd, 1'b1);
            if (i == 2) check("a_not_yet_valid", instr_valid, 1'b0);
            if (i >= 3) check("a_back_to_back", instr_valid, 1'b1);
            if (i == 3) check("a_first_instr", instr, 32'h1000);
            if (i == 4) check("a_second_pc", instr_pc, 8'h01);
        end

        // Ten-cycle stall starting at the first valid word.
        repeat (2) step(1, 0, 0, '0);
        repeat (3) step(0, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, '0);
            check("b_hold_instr", instr, 32'h1000);
            check("b_no_issue", mem_rd, 1'b0);
        end
        step(0, 1, 0, '0);
`ifdef FETCH_PERF_CNT_EN
        check("b_stall_cnt10", stall_cnt, 64'd10);
`endif
        repeat (10) step(0, 1, 0, '0);

        // Address wrap 0xFF -> 0x00.
        saw_wrap = 1'b0;
        step(0, 1, 1, 8'hF8);
        repeat (20) step(0, 1, 0, '0);
        check("c_wrap_seen", saw_wrap, 1'b1);

        // Redirect with one read in flight, then with the buffer full.
        step(0, 0, 1, 8'h20);
        step(0, 0, 0, '0);
        step(0, 0, 1, 8'h30);
        check("d_valid_before_redir", instr_valid, 1'b1);
        repeat (3) step(0, 0, 0, '0);
        check("d_full_no_rd", mem_rd, 1'b0);
        check("d_full_head_pc", instr_pc, 8'h30);
        step(0, 0, 1, 8'h40);
        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        check("d_redir_valid", instr_valid, 1'b1);
        check("d_redir_pc", instr_pc, 8'h40);
        check("d_redir_instr", instr, 32'h1040);

        // One-cycle reset pulse mid-stream.
        repeat (5) step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(0, 1, 0, '0);
        check("e_valid_after_rst", instr_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("e_stall_cnt0", stall_cnt, 64'd0);
`endif
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(0, 1, 0, '0);
            if (instr_valid) begin
                found = 1'b1;
                check("e_restart_pc", instr_pc, RST_ADDR);
            end
        end
        check("e_restart_seen", found, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic r, rdy, rv;
            logic [ADDR_W-1:0] rp;
            r   = ($urandom_range(99) == 0);
            rdy = ($urandom_range(99) < 70);
            rv  = !r && ($urandom_range(99) < 5);
            rp  = ADDR_W'($urandom);
            step(r, rdy, rv, rp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
